// File: rtl/rate_controller.sv
// rate_controller
//   Body-rate PI stage that follows the angle controller. One update runs the
//   roll, pitch and yaw axes in turn through error, proportional multiply,
//   integrator update and sum. A single signed multiplier is shared between
//   the P term (err*KP) and the I term (integrator*KI). All rates are signed
//   Q12.4.
// Ports
//   us_clk            system clock, rising edge
//   resetn            asynchronous active-low reset
//   start_signal      begin an update (sampled only while idle)
//   throttle_rate     limited throttle, Q12.4, >= 0
//   *_rate_target     per-axis rate targets, signed Q12.4
//   *_rate_actual     per-axis measured body rates, signed Q12.4
//   *_rate_cmd        registered, saturated per-axis rate commands
//   throttle_out      registered copy of the latched throttle
//   active_signal     high from LATCH through the last SUM
//   complete_signal   one-cycle pulse when the outputs update
module rate_controller #(
  parameter int                        RATE_BIT_WIDTH = 16,
  parameter logic [RATE_BIT_WIDTH-1:0] KP             = 16'h0020,
  parameter logic [RATE_BIT_WIDTH-1:0] KI             = 16'h0002,
  parameter logic [RATE_BIT_WIDTH-1:0] I_LIMIT        = 16'h0320,
  parameter logic [RATE_BIT_WIDTH-1:0] OUT_LIMIT      = 16'h0640,
  parameter logic [RATE_BIT_WIDTH-1:0] THROTTLE_ARM   = 16'h0050
) (
  input  logic                      us_clk,
  input  logic                      resetn,
  input  logic                      start_signal,
  input  logic [RATE_BIT_WIDTH-1:0] throttle_rate,
  input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_target,
  input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_target,
  input  logic [RATE_BIT_WIDTH-1:0] roll_rate_target,
  input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_actual,
  input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_actual,
  input  logic [RATE_BIT_WIDTH-1:0] roll_rate_actual,
  output logic [RATE_BIT_WIDTH-1:0] yaw_rate_cmd,
  output logic [RATE_BIT_WIDTH-1:0] pitch_rate_cmd,
  output logic [RATE_BIT_WIDTH-1:0] roll_rate_cmd,
  output logic [RATE_BIT_WIDTH-1:0] throttle_out,
  output logic                      active_signal,
  output logic                      complete_signal
);

  localparam int W = RATE_BIT_WIDTH;

  localparam logic signed [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W:0]   I_LIM = (W+1)'($signed(I_LIMIT));
  localparam logic signed [W:0]   O_LIM = (W+1)'($signed(OUT_LIMIT));

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ERR,
    S_PMUL,
    S_IUPD,
    S_SUM,
    S_DONE
  } state_t;

  state_t               state;
  logic [1:0]           axis;        // 0 roll, 1 pitch, 2 yaw
  logic signed [W-1:0]  tgt_q   [3];
  logic signed [W-1:0]  act_q   [3];
  logic signed [W-1:0]  integ_q [3];
  logic signed [W-1:0]  stage_q [3];
  logic [W-1:0]         thr_q;
  logic signed [W-1:0]  err_q;
  logic signed [W-1:0]  p_q;

  function automatic logic signed [W-1:0] sat_w1(input logic signed [W:0] v);
    if (v > (W+1)'(SMAX))      return SMAX;
    else if (v < (W+1)'(SMIN)) return SMIN;
    else                       return v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_2w(input logic signed [2*W-1:0] v);
    if (v > (2*W)'(SMAX))      return SMAX;
    else if (v < (2*W)'(SMIN)) return SMIN;
    else                       return v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] clamp_w1(input logic signed [W:0] v,
                                                   input logic signed [W:0] lim);
    if (v > lim)       return lim[W-1:0];
    else if (v < -lim) return W'(-lim);
    else               return v[W-1:0];
  endfunction

  logic signed [W:0]     err_wide;
  logic signed [W-1:0]   err_sat;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [2*W-1:0] mul_p;
  logic signed [W-1:0]   mul_sat;
  logic signed [W-1:0]   integ_next;
  logic signed [W-1:0]   sum_sat;
  logic                  armed;

  always_comb begin
    err_wide = (W+1)'(tgt_q[axis]) - (W+1)'(act_q[axis]);
    err_sat  = sat_w1(err_wide);

    // Shared multiplier: integrator*KI during SUM, err*KP otherwise (PMUL).
    if (state == S_SUM) begin
      mul_a = integ_q[axis];
      mul_b = $signed(KI);
    end else begin
      mul_a = err_q;
      mul_b = $signed(KP);
    end
    mul_p   = (2*W)'(mul_a) * (2*W)'(mul_b);
    mul_sat = sat_2w(mul_p >>> 4);

    armed      = $signed(thr_q) >= $signed(THROTTLE_ARM);
    integ_next = clamp_w1((W+1)'(integ_q[axis]) + (W+1)'(err_q), I_LIM);
    sum_sat    = clamp_w1((W+1)'(p_q) + (W+1)'(mul_sat), O_LIM);
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      axis            <= '0;
      thr_q           <= '0;
      err_q           <= '0;
      p_q             <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        tgt_q[i]   <= '0;
        act_q[i]   <= '0;
        integ_q[i] <= '0;
        stage_q[i] <= '0;
      end
      yaw_rate_cmd    <= '0;
      pitch_rate_cmd  <= '0;
      roll_rate_cmd   <= '0;
      throttle_out    <= '0;
      active_signal   <= 1'b0;
      complete_signal <= 1'b0;
    end else begin
      complete_signal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_signal) begin
            state         <= S_LATCH;
            active_signal <= 1'b1;
          end
        end
        S_LATCH: begin
          tgt_q[0] <= roll_rate_target;
          tgt_q[1] <= pitch_rate_target;
          tgt_q[2] <= yaw_rate_target;
          act_q[0] <= roll_rate_actual;
          act_q[1] <= pitch_rate_actual;
          act_q[2] <= yaw_rate_actual;
          thr_q    <= throttle_rate;
          axis     <= '0;
          state    <= S_ERR;
        end
        S_ERR: begin
          err_q <= err_sat;
          state <= S_PMUL;
        end
        S_PMUL: begin
          p_q   <= mul_sat;
          state <= S_IUPD;
        end
        S_IUPD: begin
          integ_q[axis] <= armed ? integ_next : '0;
          state         <= S_SUM;
        end
        S_SUM: begin
          // integ_q[axis] already holds the value written in IUPD.
          stage_q[axis] <= sum_sat;
          if (axis == 2'd2) begin
            state         <= S_DONE;
            active_signal <= 1'b0;
          end else begin
            axis  <= axis + 2'd1;
            state <= S_ERR;
          end
        end
        S_DONE: begin
          roll_rate_cmd   <= stage_q[0];
          pitch_rate_cmd  <= stage_q[1];
          yaw_rate_cmd    <= stage_q[2];
          throttle_out    <= thr_q;
          complete_signal <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_controller.sv
// Self-checking bench for rate_controller: a behavioural model computes each
// update's commands with integer arithmetic and a compare process checks all
// outputs every cycle; directed tests pin the model with literal values.
module tb_rate_controller;

  logic        us_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_signal = 1'b0;
  logic [15:0] throttle_rate = '0;
  logic [15:0] yaw_rate_target = '0, pitch_rate_target = '0, roll_rate_target = '0;
  logic [15:0] yaw_rate_actual = '0, pitch_rate_actual = '0, roll_rate_actual = '0;
  logic [15:0] yaw_rate_cmd, pitch_rate_cmd, roll_rate_cmd, throttle_out;
  logic        active_signal, complete_signal;

  rate_controller #(
    .RATE_BIT_WIDTH(16),
    .KP            (16'h0020),
    .KI            (16'h0002),
    .I_LIMIT       (16'h0320),
    .OUT_LIMIT     (16'h0640),
    .THROTTLE_ARM  (16'h0050)
  ) dut (
    .us_clk           (us_clk),
    .resetn           (resetn),
    .start_signal     (start_signal),
    .throttle_rate    (throttle_rate),
    .yaw_rate_target  (yaw_rate_target),
    .pitch_rate_target(pitch_rate_target),
    .roll_rate_target (roll_rate_target),
    .yaw_rate_actual  (yaw_rate_actual),
    .pitch_rate_actual(pitch_rate_actual),
    .roll_rate_actual (roll_rate_actual),
    .yaw_rate_cmd     (yaw_rate_cmd),
    .pitch_rate_cmd   (pitch_rate_cmd),
    .roll_rate_cmd    (roll_rate_cmd),
    .throttle_out     (throttle_out),
    .active_signal    (active_signal),
    .complete_signal  (complete_signal)
  );

  always #5 us_clk = ~us_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int clip(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  int          m_cnt = 0;      // cycles since the accepted start, 0 = idle
  int          m_integ [3];
  logic [15:0] m_res   [3];
  logic [15:0] m_thr;
  logic [15:0] e_cmd   [3];
  logic [15:0] e_thr = '0;
  logic        e_act = 1'b0;
  logic        e_cmp = 1'b0;

  task automatic model_compute();
    int tg [3];
    int ac [3];
    int err, p, i, thr;
    tg[0] = s16(roll_rate_target);  ac[0] = s16(roll_rate_actual);
    tg[1] = s16(pitch_rate_target); ac[1] = s16(pitch_rate_actual);
    tg[2] = s16(yaw_rate_target);   ac[2] = s16(yaw_rate_actual);
    thr = s16(throttle_rate);
    m_thr = throttle_rate;
    for (int ax = 0; ax < 3; ax++) begin
      err = clip(tg[ax] - ac[ax], -32768, 32767);
      p   = clip(2 * err, -32768, 32767);                 // gain 2.0
      if (thr < 80) m_integ[ax] = 0;                      // below 5.0: disarmed
      else          m_integ[ax] = clip(m_integ[ax] + err, -800, 800);
      i   = m_integ[ax] >>> 3;                            // gain 0.125, floor
      m_res[ax] = 16'(clip(p + i, -1600, 1600));
    end
  endtask

  always @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        m_integ[k] = 0;
        e_cmd[k]   = '0;
      end
      e_thr = '0;
      e_act = 1'b0;
      e_cmp = 1'b0;
    end else begin
      e_cmp = 1'b0;
      if (m_cnt == 0) begin
        if (start_signal) m_cnt = 1;
      end else if (m_cnt == 1) begin
        model_compute();
        m_cnt = 2;
      end else if (m_cnt == 14) begin
        for (int k = 0; k < 3; k++) e_cmd[k] = m_res[k];
        e_thr = m_thr;
        e_cmp = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      e_act = (m_cnt >= 1) && (m_cnt <= 13);
    end
  end

  logic chk_en = 1'b0;

  always @(negedge us_clk) begin
    if (chk_en) begin
      check("cyc_roll",     roll_rate_cmd,          e_cmd[0]);
      check("cyc_pitch",    pitch_rate_cmd,         e_cmd[1]);
      check("cyc_yaw",      yaw_rate_cmd,           e_cmd[2]);
      check("cyc_thr",      throttle_out,           e_thr);
      check("cyc_active",   16'(active_signal),     16'(e_act));
      check("cyc_complete", 16'(complete_signal),   16'(e_cmp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [15:0] thr,
                        input logic [15:0] rt, input logic [15:0] ra,
                        input logic [15:0] pt, input logic [15:0] pa,
                        input logic [15:0] yt, input logic [15:0] ya);
    throttle_rate     = thr;
    roll_rate_target  = rt; roll_rate_actual  = ra;
    pitch_rate_target = pt; pitch_rate_actual = pa;
    yaw_rate_target   = yt; yaw_rate_actual   = ya;
  endtask

  // Pulse start for one cycle and wait (bounded) for complete.
  task automatic run_once();
    int lat;
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    lat = 1;
    while (complete_signal !== 1'b1 && lat < 40) begin
      @(negedge us_clk);
      lat++;
    end
    check("latency", 16'(lat), 16'd15);
  endtask

  logic [15:0] armed_exp [6] = '{16'h0154, 16'h0168, 16'h017C, 16'h0190, 16'h01A4, 16'h01A4};

  initial begin
    int n, last, first;

    // Reset and idle
    repeat (3) @(negedge us_clk);
    check("rst_roll",     roll_rate_cmd,  16'h0000);
    check("rst_pitch",    pitch_rate_cmd, 16'h0000);
    check("rst_yaw",      yaw_rate_cmd,   16'h0000);
    check("rst_thr",      throttle_out,   16'h0000);
    check("rst_active",   16'(active_signal),   16'd0);
    check("rst_complete", 16'(complete_signal), 16'd0);
    resetn = 1'b1;
    chk_en = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge us_clk);
      if (complete_signal === 1'b1) n++;
    end
    check("idle_no_complete", 16'(n), 16'd0);
    check("idle_roll", roll_rate_cmd, 16'h0000);

    // Disarmed: P term only
    set_in(16'h0000, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_once();
    check("p_only_roll",  roll_rate_cmd,  16'h0140);
    check("p_only_pitch", pitch_rate_cmd, 16'h0000);
    check("p_only_yaw",   yaw_rate_cmd,   16'h0000);
    check("p_only_thr",   throttle_out,   16'h0000);

    // Armed: integrator accumulates then clamps at 0x0320
    set_in(16'h0100, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int r = 0; r < 6; r++) begin
      run_once();
      check("armed_roll", roll_rate_cmd, armed_exp[r]);
    end
    check("armed_thr", throttle_out, 16'h0100);

    // Saturation
    set_in(16'h0100, 16'h00A0, 16'h0000, 16'h0190, 16'hFE70, 16'h0000, 16'h0000);
    run_once();
    check("sat_pitch", pitch_rate_cmd, 16'h0640);
    check("sat_roll_hold", roll_rate_cmd, 16'h01A4);
    set_in(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FF0, 16'h8000);
    run_once();
    check("sat_yaw_pos", yaw_rate_cmd, 16'h0640);
    set_in(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h7FF0);
    run_once();
    check("sat_yaw_neg", yaw_rate_cmd, 16'hF9C0);

    // Handshake: start held high continuously
    set_in(16'h0100, 16'h0040, 16'h0010, 16'hFFC0, 16'h0000, 16'h0020, 16'h0030);
    @(negedge us_clk) start_signal = 1'b1;
    n = 0; last = 0; first = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge us_clk);
      if (complete_signal === 1'b1) begin
        if (n == 0) first = k;
        else check("hold_period", 16'(k - last), 16'd15);
        last = k;
        n++;
      end
    end
    start_signal = 1'b0;
    check("hold_first", 16'(first), 16'd15);
    check("hold_count", 16'(n), 16'd3);
    repeat (20) @(negedge us_clk);

    // A start during a run is ignored
    @(negedge us_clk) start_signal = 1'b1;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge us_clk);
      if (k == 1) start_signal = 1'b0;
      if (k == 5) start_signal = 1'b1;
      if (k == 6) start_signal = 1'b0;
      if (complete_signal === 1'b1) n++;
    end
    check("ignored_start", 16'(n), 16'd1);

    // Reset mid-run
    set_in(16'h0100, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    @(negedge us_clk) start_signal = 1'b1;
    @(negedge us_clk) start_signal = 1'b0;
    repeat (8) @(negedge us_clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_roll",     roll_rate_cmd,  16'h0000);
    check("midrst_pitch",    pitch_rate_cmd, 16'h0000);
    check("midrst_yaw",      yaw_rate_cmd,   16'h0000);
    check("midrst_thr",      throttle_out,   16'h0000);
    check("midrst_active",   16'(active_signal),   16'd0);
    check("midrst_complete", 16'(complete_signal), 16'd0);
    repeat (2) @(negedge us_clk);
    resetn = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge us_clk);
      if (complete_signal === 1'b1) n++;
    end
    check("midrst_no_complete", 16'(n), 16'd0);
    run_once();
    check("clean_roll",  roll_rate_cmd,  16'h0154);
    check("clean_pitch", pitch_rate_cmd, 16'h0000);
    check("clean_yaw",   yaw_rate_cmd,   16'h0000);

    repeat (3) @(negedge us_clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_controller.md
Name: rate_controller

Overview:
- Body-rate PI stage directly downstream of the angle controller.
- Consumes its limited yaw/pitch/roll rate targets and throttle, plus measured body rates from the IMU.
- Produces saturated per-axis rate commands for the motor mixer.
- Uses a start/complete handshake and time-shares one signed 16x16 multiplier across three axes.

Parameters:
- RATE_BIT_WIDTH, 16, width of all rate values; signed Q12.4 two's complement.
- KP, 16'h0020, proportional gain in Q12.4 (2.0).
- KI, 16'h0002, integral gain in Q12.4 (0.125).
- I_LIMIT, 16'h0320, integrator magnitude clamp (50.0).
- OUT_LIMIT, 16'h0640, command magnitude clamp (100.0).
- THROTTLE_ARM, 16'h0050, throttle threshold for integration (5.0).

Ports:
- us_clk, in, 1, system clock; all state updates on rising edge.
- resetn, in, 1, asynchronous active-low reset.
- start_signal, in, 1, begin one update cycle (angle controller complete).
- throttle_rate, in, 16, limited throttle, Q12.4, ≥0.
- yaw_rate_target / pitch_rate_target / roll_rate_target, in, 16 each, signed Q12.4.
- yaw_rate_actual / pitch_rate_actual / roll_rate_actual, in, 16 each, signed Q12.4 from IMU.
- yaw_rate_cmd / pitch_rate_cmd / roll_rate_cmd, out, 16 each, signed Q12.4 registered commands.
- throttle_out, out, 16, registered copy of the latched throttle.
- active_signal, out, 1, high while computing.
- complete_signal, out, 1, one-cycle pulse when outputs are updated.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All cmd outputs, throttle_out, the three integrators, complete_signal and active_signal go to 0.
  - Reset asserted mid-computation aborts the computation; no partial output update occurs.
- States: IDLE → LATCH → per axis (roll, pitch, yaw) {ERR → PMUL → IUPD → SUM} → DONE → IDLE.
  - The axis index is a 2-bit counter 0..2.
  - SUM for axes 0 and 1 returns to ERR with the index incremented; SUM for axis 2 goes to DONE.
- IDLE: a start_signal sampled high moves to LATCH. start_signal is ignored in every other state, with no queuing.
- LATCH:
  - Registers all targets, actuals and throttle_rate.
  - Inputs may change freely afterwards.
- ERR: err = sat16(target − actual), computed at 17 bits and saturated to [0x8000, 0x7FFF].
- PMUL: p = sat16((err × KP) >>> 4), with a 32-bit product and arithmetic shift.
- IUPD:
  - If latched throttle < THROTTLE_ARM (signed compare): integrator ← 0.
  - Otherwise: integrator ← clamp(integrator + err, −I_LIMIT, +I_LIMIT), computed at 17 bits before the clamp.
- SUM:
  - i = sat16((integrator_new × KI) >>> 4).
  - cmd_axis = clamp(p + i, −OUT_LIMIT, +OUT_LIMIT), summed at 17 bits.
  - The result is held in a staging register.
- DONE:
  - All three cmd outputs and throttle_out load from staging simultaneously.
  - complete_signal = 1 for exactly this cycle.
- Latency: the start edge is cycle 0; LATCH is cycle 1; axes occupy cycles 2–13; DONE is cycle 14.
  - New commands and complete_signal are visible after the cycle-14 edge.
  - Back-to-back starts are possible every 15 cycles.
- active_signal is 1 in LATCH through SUM and 0 in IDLE and DONE.
- Outputs hold their values between DONE cycles.
- Integrators persist across update cycles; they are cleared only by reset or low throttle.

Test Plan:
- Reset then idle: outputs all 0, active=0, complete=0; 20 cycles with no start → no change.
- Disarmed P only:
  - Stimulus: throttle 0x0000, roll target 0x00A0, actual 0, start pulse.
  - Response: complete at cycle 14, roll_cmd=0x0140, pitch/yaw cmd=0, integrators stay 0.
- Armed PI accumulation:
  - Stimulus: throttle 0x0100, roll target 0x00A0, actual 0; three starts.
  - Response: roll_cmd = 0x0154, then 0x0168, then 0x017C.
  - Continued repetition: integrator clamps at 0x0320, so roll_cmd saturates at 0x0140+0x0064=0x01A4.
- Saturation:
  - Stimulus: pitch target 0x0190, actual 0xFE70, armed, integrator 0.
  - Response: pitch_cmd clamps to 0x0640.
  - Stimulus: target 0x7FF0, actual 0x8000.
  - Response: error saturates to 0x7FFF; cmd = 0x0640 with no wrap.
  - Mirrored negative stimulus → cmd = 0xF9C0.
- Handshake: start held high continuously → complete pulses exactly every 15 cycles; a start pulse at cycle 5 of a run is ignored.
- Reset mid-run: resetn low at cycle 9 → all outputs and integrators 0 immediately, no complete pulse; the next start computes from clean state.
